axil_reg_slave: RTL and testbench
=================================

Name: axil_reg_slave

Overview:
- AXI4-Lite responder (slave) that exposes a bank of 32-bit read/write registers to an AXI4-Lite initiator. The initiator is the VIP master in the block-design bench, or the PS GP port on the ZedBoard.
- Accepts the write-address (AW) and write-data (W) channels independently and in any order, applies byte strobes, and returns registered B and R responses.
- Register contents are also driven out as parallel signals for downstream control logic.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 8 word slots.
- NUM_REGS, 4, number of implemented registers (slots 0..NUM_REGS-1); legal range 1..8.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- reg_out  out  32*NUM_REGS  register contents; slot k occupies bits [32k+31:32k].

Behaviour:
- Reset (ARESETN low, asynchronous):
  - all registers = 0;
  - AWREADY = WREADY = ARREADY = 1;
  - BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0;
  - both holding flags cleared. This applies mid-transaction too; any pending beat is dropped.
- Word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]. ADDR[1:0] is ignored.
- Write path:
  - One-entry AW holding register and one-entry W holding register.
  - AWREADY = ~aw_held; WREADY = ~w_held. Each channel can be accepted while the other has not yet arrived.
  - Commit fires in the first cycle where both AW and W are available (held, or handshaking this cycle) and the B slot is free (BVALID=0, or BVALID=1 with BREADY=1).
  - On commit:
    - register bytes with WSTRB[b]=1 are updated at the next edge;
    - BVALID = 1 at the next edge;
    - both holding flags are cleared.
  - Latency: AW and W both handshaking in the same cycle with B free gives BVALID in the next cycle.
  - If the B slot stays occupied, the held beats stall. No second address or data beat is accepted until they commit, so at most one write is outstanding.
  - BVALID stays high until BREADY; BRESP is stable while BVALID=1.
- Read path:
  - ARREADY = ~RVALID | RREADY.
  - On AR handshake: RDATA = register[index] and RVALID = 1 at the next edge; RDATA and RRESP are held until the RREADY handshake.
  - Back-to-back reads sustain one read per cycle while RREADY stays high.
- Same-cycle read and write to the same register: the read returns the pre-write value (read-before-write). No extra stall is inserted.
- Unimplemented slot (index >= NUM_REGS):
  - writes are discarded;
  - reads return 0;
  - response per the Optional Feature section.
- reg_out is driven directly from the register flops, so it updates in the cycle after commit.

Optional Feature:
- Macro: AXIL_REG_SLVERR_EN.
- When defined: accesses to unimplemented slots return BRESP or RRESP = 2'b10 (SLVERR).
- When undefined: every response is 2'b00 (OKAY).
- Data side effects are identical in both builds.

Test Plan:
- Write 0x00000001..0x00000004 to addresses 0x0, 0x4, 0x8, 0xC with WSTRB=0xF, then read back -> RDATA 0x1..0x4 in order, RRESP=0, BRESP=0; reg_out = {0x4,0x3,0x2,0x1}.
- W presented 3 cycles before AW (addr 0x4, data 0xDEADBEEF) -> WREADY drops after the W handshake and BVALID rises 1 cycle after the AW handshake; reading 0x4 returns 0xDEADBEEF.
- Hold BREADY=0 after a write, then issue a second write -> AWREADY and WREADY each deassert after that channel's beat is held; the second write commits the cycle BREADY goes high; two B handshakes total.
- WSTRB=0b0101 with data 0xAABBCCDD to a register holding 0x11223344 -> readback 0x11BB33DD.
- Write to 0x10 (index 4) -> readback 0; BRESP and RRESP = 2'b10 with AXIL_REG_SLVERR_EN, 2'b00 without it.
- Assert ARESETN low while BVALID=1 and an AW beat is held -> BVALID=0, AWREADY=1, all registers read 0 after reset.

Source files
------------

// File: rtl/axil_reg_slave.sv
`default_nettype none
// ============================================================================
// axil_reg_slave : AXI4-Lite register bank with independent AW/W acceptance
//                  and parallel register outputs.
// Option macro   : AXIL_REG_SLVERR_EN (SLVERR on unimplemented slots)
// Revision       : 1.0
// ============================================================================
module axil_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out
);

    localparam int         DW        = C_S_AXI_DATA_WIDTH;
    localparam int         IDX_W     = C_S_AXI_ADDR_WIDTH - 2;
    localparam int         STRB_W    = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    logic [DW-1:0]     regs [NUM_REGS];

    logic              aw_held;
    logic [IDX_W-1:0]  aw_idx_q;
    logic              w_held;
    logic [DW-1:0]     w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              commit;
    logic [IDX_W-1:0]  wr_idx;
    logic [DW-1:0]     wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic [IDX_W-1:0]  rd_idx;
    logic [DW-1:0]     rd_word;
    logic [1:0]        wr_resp;
    logic [1:0]        rd_resp;
    logic              unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = ~aw_held;
    assign S_AXI_WREADY  = ~w_held;
    assign S_AXI_ARREADY = ~S_AXI_RVALID | S_AXI_RREADY;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // A beat is usable either from its holding register or straight off the bus.
    assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_data = w_held  ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_held  ? w_strb_q : S_AXI_WSTRB;
    assign rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    assign commit = (aw_held | aw_hs) & (w_held | w_hs) & (~S_AXI_BVALID | S_AXI_BREADY);

`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    assign wr_resp = (int'(wr_idx) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = (int'(rd_idx) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held  <= 1'b0;
            aw_idx_q <= '0;
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
            end else if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (commit) begin
                w_held <= 1'b0;
            end else if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
        end
    end

    // Unimplemented slots match no k, so their writes fall away here.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_idx == IDX_W'(k)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) begin
                            regs[k][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= 2'b00;
        end else if (commit) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_resp;
        end else if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_word = regs[k];
            end
        end
    end

    // Reads sample the flops before any same-edge write lands.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= 2'b00;
        end else if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_word;
            S_AXI_RRESP  <= rd_resp;
        end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
            assign reg_out[DW*k +: DW] = regs[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
`default_nettype none
// ============================================================================
// tb_axil_reg_slave : directed self-checking bench for axil_reg_slave.
// Revision          : 1.0
// ============================================================================
module tb_axil_reg_slave;

    localparam int LIMIT = 20;
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] EXP_ERR = 2'b10;
`else
    localparam logic [1:0] EXP_ERR = 2'b00;
`endif

    logic         clk;
    logic         rst_n;
    logic [4:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [4:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] reg_out;

    int passed = 0;
    int total  = 0;
    int b_count = 0;

    axil_reg_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .NUM_REGS           (4)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bvalid && bready) b_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int  n;
        bit  aw_done, w_done, aw_now, w_now;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < LIMIT) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            step(); n++;
            if (aw_now) begin aw_done = 1; awvalid = 1'b0; end
            if (w_now)  begin w_done = 1;  wvalid = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < LIMIT) begin step(); n++; end
        if (!bvalid || !(aw_done && w_done)) begin
            total++;
            $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bvalid);
        end
        resp = bresp;
        step();
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        bit hs;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        hs = 0; n = 0;
        while (!hs && n < LIMIT) begin
            hs = arready;
            step(); n++;
        end
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < LIMIT) begin step(); n++; end
        if (!rvalid) begin
            total++;
            $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, rvalid);
        end
        d = rdata; resp = rresp;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 1;
        araddr = '0; arprot = '0; arvalid = 0; rready = 1;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        total++;
        if ({awready, wready, arready} !== 3'b111) $display("FAIL reset_ready got %b required 111", {awready, wready, arready});
        else passed++;
        total++;
        if ({bvalid, rvalid, bresp, rresp} !== 6'b0) $display("FAIL reset_resp got %b required 000000", {bvalid, rvalid, bresp, rresp});
        else passed++;
        total++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata got %h required 0", rdata);
        else passed++;
        total++;
        if (reg_out !== 128'h0) $display("FAIL reset_regs got %h required 0", reg_out);
        else passed++;
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), 32'(i + 1), 4'hF, r);
            total++;
            if (r !== 2'b00) $display("FAIL basic_bresp[%0d] got %b required 00", i, r);
            else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), d, r);
            total++;
            if (d !== 32'(i + 1) || r !== 2'b00)
                $display("FAIL basic_read[%0d] got %h/%b required %h/00", i, d, r, 32'(i + 1));
            else passed++;
        end
        total++;
        if (reg_out !== {32'h4, 32'h3, 32'h2, 32'h1})
            $display("FAIL basic_reg_out got %h required 00000004000000030000000200000001", reg_out);
        else passed++;
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0]  r;
        bready = 1'b1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        total++;
        if (wready !== 1'b0 || bvalid !== 1'b0) $display("FAIL wfirst_held got wready=%b bvalid=%b required 0/0", wready, bvalid);
        else passed++;
        step(); step();
        awaddr = 5'h4; awvalid = 1'b1;
        total++;
        if (bvalid !== 1'b0 || wready !== 1'b0) $display("FAIL wfirst_wait got bvalid=%b wready=%b required 0/0", bvalid, wready);
        else passed++;
        step();
        awvalid = 1'b0;
        total++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || wready !== 1'b1 || awready !== 1'b1)
            $display("FAIL wfirst_commit got bvalid=%b bresp=%b wready=%b awready=%b required 1/00/1/1", bvalid, bresp, wready, awready);
        else passed++;
        step();
        total++;
        if (bvalid !== 1'b0) $display("FAIL wfirst_bdone got bvalid=%b required 0", bvalid);
        else passed++;
        axi_read(5'h4, d, r);
        total++;
        if (d !== 32'hDEADBEEF) $display("FAIL wfirst_read got %h required deadbeef", d);
        else passed++;
    endtask

    task automatic test_backpressure();
        int start;
        start = b_count;
        bready = 1'b0;
        awaddr = 5'h8; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        step();
        total++;
        if (bvalid !== 1'b1 || awready !== 1'b1) $display("FAIL bp_first got bvalid=%b awready=%b required 1/1", bvalid, awready);
        else passed++;
        awaddr = 5'hC; wdata = 32'h66;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        total++;
        if ({awready, wready, bvalid} !== 3'b001) $display("FAIL bp_held got aw/w/b=%b required 001", {awready, wready, bvalid});
        else passed++;
        step(); step();
        total++;
        if (awready !== 1'b0 || reg_out[127:96] !== 32'h4 || reg_out[95:64] !== 32'h55)
            $display("FAIL bp_stall got awready=%b r3=%h r2=%h required 0/4/55", awready, reg_out[127:96], reg_out[95:64]);
        else passed++;
        bready = 1'b1;
        step();
        total++;
        if ({bvalid, awready, wready} !== 3'b111 || reg_out[127:96] !== 32'h66)
            $display("FAIL bp_commit got b/aw/w=%b r3=%h required 111/66", {bvalid, awready, wready}, reg_out[127:96]);
        else passed++;
        step();
        total++;
        if (bvalid !== 1'b0 || (b_count - start) !== 2)
            $display("FAIL bp_count got bvalid=%b handshakes=%0d required 0/2", bvalid, b_count - start);
        else passed++;
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h0, 32'h11223344, 4'hF, r);
        axi_write(5'h0, 32'hAABBCCDD, 4'b0101, r);
        axi_read(5'h0, d, r);
        total++;
        if (d !== 32'h11BB33DD) $display("FAIL strobe_read got %h required 11bb33dd", d);
        else passed++;
    endtask

    task automatic test_unimpl();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h10, 32'h12345678, 4'hF, r);
        total++;
        if (r !== EXP_ERR) $display("FAIL unimpl_bresp got %b required %b", r, EXP_ERR);
        else passed++;
        axi_read(5'h10, d, r);
        total++;
        if (d !== 32'h0 || r !== EXP_ERR) $display("FAIL unimpl_read got %h/%b required 0/%b", d, r, EXP_ERR);
        else passed++;
        axi_read(5'h1F, d, r);
        total++;
        if (d !== 32'h0 || r !== EXP_ERR) $display("FAIL unimpl_read7 got %h/%b required 0/%b", d, r, EXP_ERR);
        else passed++;
        total++;
        if (reg_out !== {32'h66, 32'h55, 32'hDEADBEEF, 32'h11BB33DD})
            $display("FAIL unimpl_regs got %h required 0000006600000055deadbeef11bb33dd", reg_out);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [4];
        exp_d = '{32'h11BB33DD, 32'hDEADBEEF, 32'h55, 32'h66};
        rready = 1'b1; arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            araddr = 5'(i * 4 + 1);
            total++;
            if (arready !== 1'b1) $display("FAIL b2b_arready[%0d] got %b required 1", i, arready);
            else passed++;
            step();
            total++;
            if (rvalid !== 1'b1 || rdata !== exp_d[i]) $display("FAIL b2b_data[%0d] got %b/%h required 1/%h", i, rvalid, rdata, exp_d[i]);
            else passed++;
        end
        arvalid = 1'b0;
        step();
        total++;
        if (rvalid !== 1'b0) $display("FAIL b2b_end got rvalid=%b required 0", rvalid);
        else passed++;
    endtask

    task automatic test_read_before_write();
        logic [31:0] d;
        logic [1:0]  r;
        bready = 1'b1; rready = 1'b1;
        awaddr = 5'h0; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h0; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'h11BB33DD || bvalid !== 1'b1 || reg_out[31:0] !== 32'hCAFEF00D)
            $display("FAIL rbw_same got rvalid=%b rdata=%h bvalid=%b r0=%h required 1/11bb33dd/1/cafef00d", rvalid, rdata, bvalid, reg_out[31:0]);
        else passed++;
        step();
        axi_read(5'h0, d, r);
        total++;
        if (d !== 32'hCAFEF00D) $display("FAIL rbw_after got %h required cafef00d", d);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        bready = 1'b0;
        awaddr = 5'h4; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        step();
        wvalid = 1'b0; awaddr = 5'h8;
        step();
        awvalid = 1'b0;
        total++;
        if (bvalid !== 1'b1 || awready !== 1'b0) $display("FAIL rstmid_pre got bvalid=%b awready=%b required 1/0", bvalid, awready);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || reg_out !== 128'h0)
            $display("FAIL rstmid_async got bvalid=%b awready=%b wready=%b regs=%h required 0/1/1/0", bvalid, awready, wready, reg_out);
        else passed++;
        step();
        rst_n = 1'b1; bready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), d, r);
            total++;
            if (d !== 32'h0) $display("FAIL rstmid_read[%0d] got %h required 0", i, d);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_backpressure();
        test_strobe();
        test_unimpl();
        test_back_to_back();
        test_read_before_write();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
